output_port_arbiter: RTL
========================

Name: output_port_arbiter

Overview:
- Shares one router output link among NUM_IN input-port FIFOs.
- Wormhole switching: a granted input holds the output from head flit through tail flit.
- Arbitration between competing packets is round-robin.
- Sits between the per-input fifo instances (empty/dout/pop) and the downstream link or FIFO (valid/ready).

Parameters:
- NUM_IN, 5, number of input ports competing for this output (N, E, S, W, local).
- DATA_WIDTH, 64, flit width; the top 2 bits carry the flit type.
- IDX_W, $clog2(NUM_IN), width of the grant index (derived, not overridden).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset; asserted when 0.
- req  in  NUM_IN  input i's route computation selects this output.
- fifo_empty  in  NUM_IN  empty flag of input FIFO i.
- fifo_dout  in  NUM_IN x DATA_WIDTH  head flit of input FIFO i.
- fifo_pop  out  NUM_IN  one-hot pop to the granted FIFO.
- out_valid  out  1  out_data holds a valid flit.
- out_data  out  DATA_WIDTH  forwarded flit.
- out_ready  in  1  downstream can accept a flit (e.g. !full).
- grant_idx  out  IDX_W  currently locked input; 0 when idle.
- locked  out  1  packet in flight.
- proto_err  out  1  sticky protocol-error flag.

Behaviour:
- Flit type is fifo_dout[i][DATA_WIDTH-1:DATA_WIDTH-2]:
  - 2'b01 HEAD, 2'b00 BODY, 2'b10 TAIL, 2'b11 SINGLE (head and tail).
  - is_head = bit DATA_WIDTH-2; is_tail = bit DATA_WIDTH-1.
- Reset (reset==0, async): state=IDLE, rr_ptr=0, grant_idx=0, locked=0, proto_err=0. All outputs are 0 while reset is held.
- FSM IDLE:
  - Eligible set = req & ~fifo_empty & is_head.
  - If any input is eligible, pick the first eligible index at or after rr_ptr (wrapping modulo NUM_IN).
  - Register that index as grant_idx and go to LOCKED.
  - No flit is transferred in the arbitration cycle, so arbitration latency is 1 cycle.
- FSM LOCKED:
  - out_valid = !fifo_empty[grant_idx]; out_data = fifo_dout[grant_idx] (combinational pass-through).
  - Transfer = out_valid && out_ready; fifo_pop[grant_idx] = transfer; all other pops are 0.
  - Transfer of a flit with is_tail=1: go to IDLE and set rr_ptr = (grant_idx+1) mod NUM_IN. The wrap at NUM_IN-1 goes to 0.
  - Transfer with is_tail=0: stay LOCKED.
- out_valid=0 and fifo_pop=0 in IDLE.
- Boundary rules:
  - Granted FIFO empty mid-packet: stay LOCKED with out_valid=0. Competing requesters cannot steal the output.
  - out_ready=0: hold out_data, no pop, state unchanged.
  - req[grant_idx] dropped while LOCKED: ignored; the lock holds until the tail transfers.
  - SINGLE flit: transferred, and the arbiter returns to IDLE in the same cycle.
  - A new packet can be granted no earlier than the cycle after a tail transfer, giving a 1-cycle bubble per packet.
- Protocol error (proto_err set, cleared only by reset):
  - In IDLE, an input has req=1 and !empty but a non-head flit at its FIFO head.
  - In LOCKED, the flit at the granted FIFO head has is_head=1.
  - A non-head flit in IDLE is never granted. A head flit in LOCKED is still forwarded as-is.
- Only one packet can be in flight per output, so a flit can be popped from at most one FIFO per cycle.

Optional Feature:
- Macro: OUTPUT_PORT_ARB_PERF_EN.
- Defined:
  - Adds output ports pkt_count (32b) and stall_count (32b), both reset to 0 and wrapping on overflow.
  - pkt_count increments on each tail transfer.
  - stall_count increments each LOCKED cycle with out_valid=1 && out_ready=0.
- Undefined: ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package router_pkg holds:
  - flit_type_e (HEAD, BODY, TAIL, SINGLE).
  - Constants FLIT_TYPE_MSB=DATA_WIDTH-1 and FLIT_TYPE_LSB=DATA_WIDTH-2.
  - arb_state_e (IDLE, LOCKED).
- Sub-module rr_arbiter #(NUM_IN): purely combinational; inputs eligible and rr_ptr; outputs gnt_valid and gnt_idx. It is reused by other router outputs.

Test Plan:
- Reset and idle: hold reset=0 for 2 cycles, all req=0, then release -> out_valid=0, locked=0, fifo_pop=0, proto_err=0, grant_idx=0.
- Single packet: input 2 holds HEAD, BODY, TAIL with req[2]=1 and out_ready=1 -> locked rises 1 cycle after req; the 3 flits appear on consecutive cycles with fifo_pop=5'b00100; the FSM is IDLE after the TAIL and rr_ptr=3.
- Round-robin: inputs 0, 1 and 4 each request a SINGLE flit continuously with rr_ptr=0 -> grant order is 0, 1, 4, 0, 1, 4, with a 1-cycle gap between grants.
- Lock under contention: input 1 mid-packet and FIFO empty for 3 cycles while input 3 requests with a HEAD -> out_valid=0, grant_idx stays 1, no pop on input 3 until input 1's TAIL transfers.
- Backpressure: out_ready=0 for 4 cycles mid-packet -> out_data is stable, no pops, and the flit order is preserved after out_ready=1; with PERF_EN, stall_count=4.
- Protocol error: input 0 has req=1 and a BODY flit at its FIFO head while IDLE -> not granted and proto_err=1. Asserting reset=0 mid-packet (async) -> locked=0 and proto_err=0 immediately.

Source files
------------

// File: rtl/router_pkg.sv
// Shared router types: flit type encoding, arbiter FSM states and flit
// decode helpers. Imported by output_port_arbiter and rr_arbiter users.
package router_pkg;

  localparam int unsigned FLIT_DATA_WIDTH = 64;
  localparam int unsigned FLIT_TYPE_MSB   = FLIT_DATA_WIDTH - 1;
  localparam int unsigned FLIT_TYPE_LSB   = FLIT_DATA_WIDTH - 2;

  typedef enum logic [1:0] {
    BODY   = 2'b00,
    HEAD   = 2'b01,
    TAIL   = 2'b10,
    SINGLE = 2'b11
  } flit_type_e;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  // A SINGLE flit opens and closes a packet, so it counts as both.
  function automatic logic flit_is_head(input flit_type_e t);
    return (t == HEAD) || (t == SINGLE);
  endfunction

  function automatic logic flit_is_tail(input flit_type_e t);
    return (t == TAIL) || (t == SINGLE);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first eligible index at or after rr_ptr,
// wrapping modulo NUM_IN.
// Ports: eligible (request vector), rr_ptr (priority start),
//        gnt_valid (any eligible), gnt_idx (chosen index).
module rr_arbiter #(
  parameter int unsigned NUM_IN = 5,
  parameter int unsigned IDX_W  = $clog2(NUM_IN)
) (
  input  logic [NUM_IN-1:0] eligible,
  input  logic [IDX_W-1:0]  rr_ptr,
  output logic              gnt_valid,
  output logic [IDX_W-1:0]  gnt_idx
);

  // Scan offsets 0..NUM_IN-1 from rr_ptr; the first hit wins.
  always_comb begin
    int unsigned j;
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    j         = 0;
    for (int unsigned k = 0; k < NUM_IN; k++) begin
      j = 32'(rr_ptr) + k;
      if (j >= NUM_IN) j = j - NUM_IN;
      if (!gnt_valid && eligible[IDX_W'(j)]) begin
        gnt_valid = 1'b1;
        gnt_idx   = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/output_port_arbiter.sv
// Wormhole output-port arbiter: locks one input FIFO onto the output link
// from head flit to tail flit, round-robin between competing packets.
// Ports: clk, reset (async, active-low), req/fifo_empty/fifo_dout from the
//        input FIFOs, fifo_pop (one-hot) back to them, out_valid/out_data/
//        out_ready toward the link, grant_idx/locked status, sticky proto_err.
// Optional: define OUTPUT_PORT_ARB_PERF_EN to add pkt_count and stall_count.
module output_port_arbiter
  import router_pkg::*;
#(
  parameter int unsigned NUM_IN     = 5,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned IDX_W      = $clog2(NUM_IN)
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [NUM_IN-1:0]                   req,
  input  logic [NUM_IN-1:0]                   fifo_empty,
  input  logic [NUM_IN-1:0][DATA_WIDTH-1:0]   fifo_dout,
  output logic [NUM_IN-1:0]                   fifo_pop,
  output logic                                out_valid,
  output logic [DATA_WIDTH-1:0]               out_data,
  input  logic                                out_ready,
  output logic [IDX_W-1:0]                    grant_idx,
  output logic                                locked,
`ifdef OUTPUT_PORT_ARB_PERF_EN
  output logic [31:0]                         pkt_count,
  output logic [31:0]                         stall_count,
`endif
  output logic                                proto_err
);

  localparam int unsigned TYPE_MSB = DATA_WIDTH - 1;
  localparam int unsigned TYPE_LSB = DATA_WIDTH - 2;

  arb_state_e        state_q;
  logic [IDX_W-1:0]  rr_ptr_q;
  logic [IDX_W-1:0]  grant_idx_q;
  logic              first_sent_q;
  logic              proto_err_q;

  logic [NUM_IN-1:0] is_head;
  logic [NUM_IN-1:0] is_tail;
  logic [NUM_IN-1:0] eligible;
  logic              idle_err;
  logic              gnt_valid;
  logic [IDX_W-1:0]  gnt_idx;
  logic              transfer;
  logic              tail_xfer;
  logic              locked_err;
  logic [IDX_W-1:0]  next_ptr;

  // Per-input flit type decode from the top two bits of the head flit.
  for (genvar g = 0; g < NUM_IN; g++) begin : g_decode
    flit_type_e ft;
    assign ft         = flit_type_e'(fifo_dout[g][TYPE_MSB:TYPE_LSB]);
    assign is_head[g] = flit_is_head(ft);
    assign is_tail[g] = flit_is_tail(ft);
  end

  assign eligible = req & ~fifo_empty & is_head;
  assign idle_err = |(req & ~fifo_empty & ~is_head);

  rr_arbiter #(
    .NUM_IN (NUM_IN),
    .IDX_W  (IDX_W)
  ) u_rr_arbiter (
    .eligible  (eligible),
    .rr_ptr    (rr_ptr_q),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  // Locked datapath: the granted FIFO head passes straight to the link.
  always_comb begin
    out_valid  = 1'b0;
    out_data   = '0;
    fifo_pop   = '0;
    transfer   = 1'b0;
    tail_xfer  = 1'b0;
    locked_err = 1'b0;
    if (state_q == LOCKED) begin
      out_valid             = !fifo_empty[grant_idx_q];
      out_data              = fifo_dout[grant_idx_q];
      transfer              = out_valid && out_ready;
      fifo_pop[grant_idx_q] = transfer;
      tail_xfer             = transfer && is_tail[grant_idx_q];
      // The opening head is presented while locked; only a later head is bad.
      locked_err            = first_sent_q && out_valid && is_head[grant_idx_q];
    end
  end

  assign next_ptr = (grant_idx_q == IDX_W'(NUM_IN - 1)) ? '0
                                                         : grant_idx_q + IDX_W'(1);

  // Arbitration FSM with registered status outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      grant_idx_q  <= '0;
      first_sent_q <= 1'b0;
      proto_err_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (idle_err) proto_err_q <= 1'b1;
          if (gnt_valid) begin
            state_q      <= LOCKED;
            grant_idx_q  <= gnt_idx;
            first_sent_q <= 1'b0;
          end
        end
        LOCKED: begin
          if (locked_err) proto_err_q <= 1'b1;
          if (transfer) first_sent_q <= 1'b1;
          if (tail_xfer) begin
            state_q     <= IDLE;
            rr_ptr_q    <= next_ptr;
            grant_idx_q <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign grant_idx = grant_idx_q;
  assign locked    = (state_q == LOCKED);
  assign proto_err = proto_err_q;

`ifdef OUTPUT_PORT_ARB_PERF_EN
  logic [31:0] pkt_count_q;
  logic [31:0] stall_count_q;
  logic        stall;

  assign stall = out_valid && !out_ready;

  // Free-running, wrapping performance counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pkt_count_q   <= '0;
      stall_count_q <= '0;
    end else begin
      if (tail_xfer) pkt_count_q   <= pkt_count_q + 32'd1;
      if (stall)     stall_count_q <= stall_count_q + 32'd1;
    end
  end

  assign pkt_count   = pkt_count_q;
  assign stall_count = stall_count_q;
`endif

endmodule
